glitch_detector: RTL
====================

# glitch_detector

Receive-side companion to the PLL-clocked glitch generator. Samples an asynchronous target signal (the divided/glitched clock returned from the device under attack) in the PLL clock domain and measures the width of every high and low phase. It flags phases shorter than a programmed minimum as glitches and counts them. It sits next to the generator and feeds status LEDs/PMOD debug pins or a host readout.

## Interface
- `WIDTH`, 24: width-counter bits; the maximum measurable phase is 2^WIDTH-1 cycles.
- `MIN_PULSE`, 8: a phase shorter than this many CLK cycles is a glitch. Legal range 1 to 2^WIDTH-1.
- `CLK` in 1: PLL output clock; all logic is on its rising edge.
- `RST` in 1: reset, synchronous and active-high.
- `SIG_IN` in 1: asynchronous monitored signal.
- `CLR` in 1: synchronous clear of `GLITCH_CNT` and `MIN_WIDTH`.
- `WIDTH_VALID` out 1: one-cycle strobe; `LAST_WIDTH`/`LAST_LEVEL` were updated this cycle.
- `LAST_WIDTH` out WIDTH: width in cycles of the phase that just ended.
- `LAST_LEVEL` out 1: level of the phase that just ended.
- `GLITCH` out 1: one-cycle strobe, coincident with `WIDTH_VALID`, when `LAST_WIDTH < MIN_PULSE`.
- `GLITCH_CNT` out 16: glitch count; saturates at 16'hFFFF.
- `STUCK` out 1: `SIG_IN` has not toggled for 2^WIDTH-1 cycles.
- `MIN_WIDTH` out WIDTH: smallest reported width since reset or `CLR` (see Configuration).

## Operation
- **Synchronizer and edge detect**
  - `SIG_IN` passes through two flops `s1`, `s2`, plus a history flop `s3`.
  - edge = `s2 ^ s3`; the current level is `s2`.
- **Phase counter `cnt`**
  - On an edge: `cnt <= 1`.
  - Otherwise: `cnt <= cnt+1`, saturating at all-ones.
  - A phase where `s2` is stable for exactly N cycles ends with `cnt == N` on its closing edge.
- **FSM states** (reset state is IDLE):
  - IDLE, edge: go to MEASURE; `cnt <= 1`; no width report, because the first phase is partial.
  - IDLE, no edge: stay in IDLE.
  - MEASURE, edge: `LAST_WIDTH <= cnt`, `LAST_LEVEL <= s3`, `WIDTH_VALID <= 1`.
    - If `cnt < MIN_PULSE`: `GLITCH <= 1` and `GLITCH_CNT` increments, saturating.
  - MEASURE, `cnt` reaches all-ones: `STUCK <= 1`, go to IDLE, no report.
  - `STUCK` clears on the next edge, which is handled as the IDLE edge above.
- **CLR**
  - Sets `GLITCH_CNT <= 0` and `MIN_WIDTH <= all-ones`.
  - If a glitch report lands in the same cycle, the clear applies first and the glitch is still counted: `GLITCH_CNT = 1`.
- **RST**
  - Resets all flops: state IDLE, `s1`/`s2`/`s3` = 0, `cnt` = 0.
  - Outputs: `WIDTH_VALID` = 0, `GLITCH` = 0, `LAST_WIDTH` = 0, `LAST_LEVEL` = 0, `GLITCH_CNT` = 0, `STUCK` = 0, `MIN_WIDTH` = all-ones.
  - RST mid-phase discards the partial measurement. The first edge after reset re-arms only; it does not report.

## Timing
- Latency: a `SIG_IN` transition sampled at edge k is in `s2` after edge k+1. The strobes `WIDTH_VALID`/`GLITCH` are high for the cycle following edge k+2.
- Strobes are exactly one cycle wide. Reports can occur on consecutive cycles: the minimum phase is 1 cycle, so the report rate is one per cycle max.
- Widths are quantized to CLK. Phases shorter than one CLK period may be missed entirely; this is an accepted limitation.
- `LAST_WIDTH`, `LAST_LEVEL` and `MIN_WIDTH` hold their values between strobes.
- `STUCK` rises on the cycle after `cnt` saturates.

## Configuration
- `GLITCH_DETECT_MINWIDTH_EN`
  - Defined: `MIN_WIDTH <= min(MIN_WIDTH, cnt)` on every width report. The update is registered together with `LAST_WIDTH`.
  - Undefined: the tracking logic is omitted and `MIN_WIDTH` is tied to all-ones. The port list is unchanged.

## Test plan
All scenarios use `WIDTH`=16, `MIN_PULSE`=8, `SIG_IN` driven synchronously to CLK.
- Reset, then a square wave of 20 cycles high / 20 low.
  - No report on the first edge.
  - Every later edge gives `WIDTH_VALID` with `LAST_WIDTH`=20 and `LAST_LEVEL` alternating.
  - `GLITCH` stays 0.
- Inject a 3-cycle high pulse into a 20/20 wave -> `GLITCH` pulses once with `LAST_WIDTH`=3, `LAST_LEVEL`=1, `GLITCH_CNT`=1.
- Boundary pulses of 7 and 8 cycles.
  - Width 7: `GLITCH`, `GLITCH_CNT` increments.
  - Width 8: no glitch.
  - `MIN_WIDTH`=7 when the macro is defined; all-ones when it is undefined.
- Hold `SIG_IN` constant for 70000 cycles.
  - `STUCK`=1 after 65535 cycles, with no report.
  - The next edge clears `STUCK` without reporting; the following edge reports normally.
- Assert `CLR` in the same cycle as a 2-cycle glitch report while `GLITCH_CNT`=5 -> `GLITCH_CNT`=1 on the next cycle.
- Assert RST mid-phase -> all outputs take their reset values; the first subsequent edge produces no report.

Source files
------------

// File: rtl/glitch_detector.sv
// Measures high/low phase widths of an asynchronous signal in the CLK domain and flags short phases as glitches.
// Optional minimum-width tracking is enabled by defining GLITCH_DETECT_MINWIDTH_EN.
module glitch_detector #(
  parameter int WIDTH     = 24,
  parameter int MIN_PULSE = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sig_in_i,
  input  logic             clr_i,
  output logic             width_valid_o,
  output logic [WIDTH-1:0] last_width_o,
  output logic             last_level_o,
  output logic             glitch_o,
  output logic [15:0]      glitch_cnt_o,
  output logic             stuck_o,
  output logic [WIDTH-1:0] min_width_o
);

  localparam logic [WIDTH-1:0] CNT_MAX     = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MIN_PULSE_C = WIDTH'(MIN_PULSE);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_e;

  state_e           state_q;
  logic             s1_q, s2_q, s3_q;
  logic             edge_s;
  logic             report_s;
  logic             glitch_s;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [15:0]      glitch_cnt_q, glitch_cnt_d;
  logic [15:0]      glitch_base_s;
  logic             width_valid_q;
  logic             glitch_q;
  logic             last_level_q;
  logic             stuck_q;
  logic [WIDTH-1:0] last_width_q;

  // Two-flop synchronizer plus history flop for edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_in_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign edge_s   = s2_q ^ s3_q;
  assign report_s = (state_q == ST_MEASURE) && edge_s;
  assign glitch_s = report_s && (cnt_q < MIN_PULSE_C);

  // Phase counter next state: restart on every edge, saturate at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (edge_s) begin
      cnt_d = CNT_ONE;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = CNT_MAX;
    end
  end

  // Glitch counter next state: a clear takes effect before a coincident glitch is counted.
  always_comb begin
    glitch_base_s = clr_i ? 16'h0000 : glitch_cnt_q;
    glitch_cnt_d  = glitch_base_s;
    if (glitch_s && (glitch_base_s != 16'hFFFF)) begin
      glitch_cnt_d = glitch_base_s + 16'h0001;
    end else begin
      glitch_cnt_d = glitch_base_s;
    end
  end

  // Measurement FSM with registered report strobes and status.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      cnt_q         <= {WIDTH{1'b0}};
      glitch_cnt_q  <= 16'h0000;
      width_valid_q <= 1'b0;
      glitch_q      <= 1'b0;
      last_width_q  <= {WIDTH{1'b0}};
      last_level_q  <= 1'b0;
      stuck_q       <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      glitch_cnt_q  <= glitch_cnt_d;
      width_valid_q <= 1'b0;
      glitch_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // The first phase after arming is partial, so it is never reported.
          if (edge_s) begin
            state_q <= ST_MEASURE;
            stuck_q <= 1'b0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_MEASURE: begin
          if (report_s) begin
            last_width_q  <= cnt_q;
            last_level_q  <= s3_q;
            width_valid_q <= 1'b1;
            glitch_q      <= glitch_s;
          end else if (cnt_q == CNT_MAX) begin
            stuck_q <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_MEASURE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef GLITCH_DETECT_MINWIDTH_EN
  logic [WIDTH-1:0] min_width_q, min_width_d;
  logic [WIDTH-1:0] min_base_s;

  // Running minimum of reported widths; a clear restarts it before a coincident report.
  always_comb begin
    min_base_s  = clr_i ? CNT_MAX : min_width_q;
    min_width_d = min_base_s;
    if (report_s && (cnt_q < min_base_s)) begin
      min_width_d = cnt_q;
    end else begin
      min_width_d = min_base_s;
    end
  end

  // Minimum-width register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      min_width_q <= CNT_MAX;
    end else begin
      min_width_q <= min_width_d;
    end
  end

  assign min_width_o = min_width_q;
`else
  assign min_width_o = CNT_MAX;
`endif

  assign width_valid_o = width_valid_q;
  assign last_width_o  = last_width_q;
  assign last_level_o  = last_level_q;
  assign glitch_o      = glitch_q;
  assign glitch_cnt_o  = glitch_cnt_q;
  assign stuck_o       = stuck_q;

endmodule
